ped_request_conditioner: RTL
============================

Name: ped_request_conditioner

Overview:
Upstream stage for the two-way intersection controller. Conditions the two raw pedestrian push-buttons: synchronizes, debounces, latches one request per direction, and holds it until the controller serves that direction. Drives the active-low crosswalk_0/crosswalk_1 request inputs of the intersection, and flags requests that waited too long.

Parameters:
DEBOUNCE, 4, consecutive cycles a synchronized level must hold before it is accepted (min 1)
LOCKOUT, 10, cycles after service ends during which presses are ignored (min 1)
MAX_WAIT, 50, cycles in PENDING after which wait_overrun sets (min 1)
CNT_W, 8, width of the press counters

Ports:
clk  input  1  clock, posedge
reset_n  input  1  synchronous, active-high reset (asserted = 1 despite the suffix)
btn_n  input  2  raw async push-buttons, active-low; bit0 = direction 0, bit1 = direction 1
serve  input  2  per-direction service indication from the controller (1 = that direction's walk/green phase active)
clear_flags  input  1  one-cycle pulse; clears both wait_overrun bits
crosswalk_0  output  1  active-low latched request for direction 0, to the intersection
crosswalk_1  output  1  active-low latched request for direction 1
req_pending  output  2  active-high mirror of the latched requests
wait_overrun  output  2  sticky; request waited MAX_WAIT cycles
press_cnt_0  output  CNT_W  accepted debounced presses, direction 0, saturating
press_cnt_1  output  CNT_W  same, direction 1

Behaviour:
- Two identical, independent channels. All state is updated on posedge clk.
- Reset (reset_n=1 at an edge): sync flops=1, debounced level=1, state=IDLE, all counters=0, crosswalk_x=1, req_pending=0, wait_overrun=0, press_cnt=0. Reset mid-request drops the request with no residue.
- Sync: 2-FF synchronizer on each btn_n bit.
- Debounce: counter increments while sync output != debounced level and resets to 0 when they match. When the counter reaches DEBOUNCE-1 and the levels still differ, the debounced level takes the sync value and the counter clears. Glitches shorter than DEBOUNCE cycles have no effect.
- Press event: debounced level falls 1->0, detected against a registered copy. Exactly one event per press. Release generates no event.
- press_cnt_x increments on every press event in any state and saturates at 2^CNT_W-1.
- Latency: the first edge that samples btn low is edge k. If btn stays stable, req_pending is high after edge k+DEBOUNCE+2.
- Channel FSM:
  - IDLE: press event -> PENDING; clear wait_cnt. serve is ignored.
  - PENDING: wait_cnt increments each cycle and saturates at MAX_WAIT. At the edge where wait_cnt becomes MAX_WAIT, wait_overrun_x sets. serve_x=1 -> SERVING. Presses are counted only.
  - SERVING: request cleared. serve_x=0 -> LOCKOUT; load lockout counter. Presses are counted only.
  - LOCKOUT: the channel remains in LOCKOUT exactly LOCKOUT cycles, then -> IDLE. Presses are counted only.
- Outputs: req_pending_x = (state==PENDING). crosswalk_x = ~req_pending_x. Both decode from registered state and are glitch-free.
- Simultaneous events:
  - Press event in IDLE while serve_x=1: goes to PENDING. It moves to SERVING the next cycle if serve_x is still 1.
  - serve_x and the overrun-setting edge in the same cycle: overrun sets and the state moves to SERVING.
  - clear_flags and an overrun set in the same cycle: set wins.
- wait_overrun_x is cleared only by clear_flags or reset.

Test Plan:
- Reset, then btn_n=2'b10 held from edge k with DEBOUNCE=4 -> req_pending=2'b01 and crosswalk_0=0 after edge k+6. crosswalk_1 stays 1. press_cnt_0=1.
- Glitch test: btn_n[0] low for 3 cycles, then high (DEBOUNCE=4) -> no request, press_cnt_0=0. Repeat with 4 cycles -> one request.
- Service/lockout: pending ch0, serve=2'b01 for 5 cycles, then 0 -> req_pending[0]=0 the cycle after serve rises. A press during serve and during the following 10 cycles gives no new request but press_cnt_0 increments. A press after lockout expires latches a new request.
- Overrun: hold ch1 pending with serve=0 -> wait_overrun[1]=1 exactly 50 cycles after entering PENDING and it stays set. clear_flags pulse -> 0. clear_flags on the setting edge -> stays 1.
- Saturation and independence: with CNT_W=8, 260 debounced presses on ch0 -> press_cnt_0=255. Ch1 state and counters are unaffected.
- Reset mid-request: ch0 PENDING with overrun set, reset_n=1 for one cycle -> all outputs at reset values next cycle. No request reappears until a new press.

Source files
------------

// File: rtl/ped_request_conditioner.sv
`timescale 1ns/1ps
// Pedestrian button conditioner: 2-FF sync, debounce, one latched request per direction held until served.
// Press to req_pending takes DEBOUNCE+2 edges; there is no backpressure, and release is driven only by serve.
module ped_request_conditioner #(
    parameter int DEBOUNCE = 4,
    parameter int LOCKOUT  = 10,
    parameter int MAX_WAIT = 50,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       btn_n,
    input  logic [1:0]       serve,
    input  logic             clear_flags,
    output logic             crosswalk_0,
    output logic             crosswalk_1,
    output logic [1:0]       req_pending,
    output logic [1:0]       wait_overrun,
    output logic [CNT_W-1:0] press_cnt_0,
    output logic [CNT_W-1:0] press_cnt_1
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int LK_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
    localparam int WT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_SERVING,
        ST_LOCKOUT
    } state_t;

    logic [CNT_W-1:0] pc [2];

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic            sync1;
        logic            sync2;
        logic            deb;
        logic            deb_q;
        logic [DB_W-1:0] db_cnt;
        logic [WT_W-1:0] wait_cnt;
        logic [LK_W-1:0] lk_cnt;
        logic [CNT_W-1:0] cnt;
        logic            ovr;
        logic            press;
        logic            ovr_set;
        state_t          state;
        state_t          state_nxt;

        always_ff @(posedge clk) begin
            if (reset_n) begin
                sync1  <= 1'b1;
                sync2  <= 1'b1;
                deb    <= 1'b1;
                deb_q  <= 1'b1;
                db_cnt <= '0;
            end else begin
                sync1 <= btn_n[ch];
                sync2 <= sync1;
                deb_q <= deb;
                if (sync2 == deb) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
                    deb    <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        // Only the 1->0 edge of the debounced level is a press; release is silent.
        assign press   = deb_q & ~deb;
        assign ovr_set = (state == ST_PENDING) && (wait_cnt == WT_W'(MAX_WAIT - 1));

        always_comb begin
            state_nxt = state;
            case (state)
                ST_IDLE:    if (press)      state_nxt = ST_PENDING;
                ST_PENDING: if (serve[ch])  state_nxt = ST_SERVING;
                ST_SERVING: if (!serve[ch]) state_nxt = ST_LOCKOUT;
                ST_LOCKOUT: if (lk_cnt == '0) state_nxt = ST_IDLE;
                default:                    state_nxt = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset_n) begin
                state    <= ST_IDLE;
                wait_cnt <= '0;
                lk_cnt   <= '0;
                cnt      <= '0;
                ovr      <= 1'b0;
            end else begin
                state <= state_nxt;
                if (state == ST_IDLE && press) begin
                    wait_cnt <= '0;
                end else if (state == ST_PENDING && wait_cnt != WT_W'(MAX_WAIT)) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                // Loaded with LOCKOUT-1 so the channel spends exactly LOCKOUT cycles there.
                if (state == ST_SERVING && !serve[ch]) begin
                    lk_cnt <= LK_W'(LOCKOUT - 1);
                end else if (state == ST_LOCKOUT && lk_cnt != '0) begin
                    lk_cnt <= lk_cnt - 1'b1;
                end
                ovr <= (ovr & ~clear_flags) | ovr_set;
                if (press && cnt != '1) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign req_pending[ch]  = (state == ST_PENDING);
        assign wait_overrun[ch] = ovr;
        assign pc[ch]           = cnt;
    end

    assign crosswalk_0 = ~req_pending[0];
    assign crosswalk_1 = ~req_pending[1];
    assign press_cnt_0 = pc[0];
    assign press_cnt_1 = pc[1];

endmodule
